uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Serial-to-parallel end of the UART link. Recovers frames from serial_data_in by OVERSAMPLE-x mid-bit sampling.
//  Line frame is LSB first: start(0), DATA_SIZE data bits, parity bit = ^data (even parity), stop(1); idle line high.
//  Good and parity-flagged words go to an internal RX FIFO that the bus drains. An 8-bit status register reports state and errors.
// PARAMETERS
//  DATA_SIZE       8                     data bits per frame
//  SIZE_FIFO       8                     RX FIFO depth in words; power of 2
//  OVERSAMPLE      16                    clk cycles per bit period; even, >=4
//  BIT_COUNT_SIZE  $clog2(DATA_SIZE+1)   width of received-bit counter
// PORTS
//  clk              in   1          single clock, OVERSAMPLE x baud rate
//  reset            in   1          synchronous, active-high
//  serial_data_in   in   1          asynchronous serial line
//  read_data        in   1          pop head of RX FIFO; ignored when empty
//  clear_status     in   1          clear sticky error bits
//  bus_data         out  DATA_SIZE  head of RX FIFO (first-word fall-through); 0 when empty
//  status_register  out  8          {3'b0, overrun_error, framing_error, parity_error, full, empty}
// BEHAVIOUR
//  Reset (sync, clk edge with reset=1) overrides everything:
//   - FSM goes to IDLE; counters are cleared; FIFO is emptied.
//   - Synchronizer flops are set to 1. Sticky errors are cleared.
//   - bus_data = 0; status_register = 8'h01. A frame in flight is abandoned.
//  Input path: 2-flop synchronizer, then rx_s. Falling edge = rx_s_prev=1 and rx_s=0.
//  FSM states: IDLE, START, DATA, PARITY, STOP. tick_cnt counts 0..OVERSAMPLE-1.
//   - IDLE -> START on falling edge; tick_cnt cleared.
//   - START: at tick_cnt==OVERSAMPLE/2-1 (mid start bit):
//     - rx_s=1: false start, back to IDLE, no flags.
//     - rx_s=0: go to DATA, tick_cnt cleared.
//   - DATA: sample rx_s at each tick_cnt==OVERSAMPLE-1.
//     - Sampled bit shifts into shift_reg MSB-side, so the first bit lands in bit 0 after DATA_SIZE samples.
//     - bit_count increments per sample; after DATA_SIZE samples go to PARITY.
//   - PARITY: sample one bit one period later; par_bad = sample ^ (^shift_reg). Go to STOP.
//   - STOP: sample one period later, then always return to IDLE.
//     - Stop sampled 1: push shift_reg into FIFO. Set parity_error if par_bad; the word is still stored.
//     - Stop sampled 0: framing_error set; word discarded; parity result ignored.
//     - A line held low (break) cannot retrigger: the next frame needs a 1 then 0 edge.
//  Latency: the word is visible on bus_data, with empty=0, 1 cycle after the stop-bit sample edge.
//  FIFO rules:
//   - Push when full with no read in the same cycle: word dropped, overrun_error set, contents unchanged.
//   - Push and read in the same cycle: both happen, including when full (count unchanged) or empty (word becomes head next cycle).
//   - Read when empty: no effect.
//   - Pointers wrap modulo SIZE_FIFO; count width is $clog2(SIZE_FIFO+1).
//  Sticky errors: clear_status clears all three. If an error event coincides with clear_status, set wins.
//  Status bits full and empty are live, not sticky.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, PARITY, STOP}.
//   - Status bit index localparams ST_EMPTY=0, ST_FULL=1, ST_PARITY=2, ST_FRAMING=3, ST_OVERRUN=4.
//  Sub-module uart_sync_fifo: single-clock, sync active-high reset, FWFT, params DATA_SIZE/SIZE_FIFO.
//  Synchronizer, FSM, tick/bit counters and shift register stay inline.
// TESTING (OVERSAMPLE=16, DATA_SIZE=8, SIZE_FIFO=8, 16 clk per bit)
//  1 Frame 8'hA5 (line 0,1,0,1,0,0,1,0,1,0,1) -> bus_data=8'hA5, status=8'h00, no error bits.
//  2 Frame 8'h07 sent with parity 0 -> bus_data=8'h07, status=8'h04; clear_status pulse -> status=8'h00.
//  3 Frame 8'h3C with stop=0 -> FIFO stays empty, status=8'h09; a following good 8'h3C frame is received.
//  4 Line low for 6 clk then high -> no state change, status stays 8'h01.
//  5 Nine frames 8'h00..8'h08, no reads -> full after 8, status=8'h12.
//    Reads then return 8'h00..8'h07 in order; 8'h08 is lost.
//  6 reset asserted mid-DATA of 8'hFF -> status=8'h01 next cycle.
//    A following 8'h55 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FSM state encoding and status bit positions.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_PARITY  = 2;
  localparam int ST_FRAMING = 3;
  localparam int ST_OVERRUN = 4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is visible the cycle after a push into an empty FIFO.
// A push while full is dropped unless a pop happens in the same cycle; a pop while empty is ignored.
module uart_sync_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int SIZE_FIFO = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout,
  output logic                 full,
  output logic                 empty
);

  localparam int PW = (SIZE_FIFO > 1) ? $clog2(SIZE_FIFO) : 1;
  localparam int CW = $clog2(SIZE_FIFO + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(SIZE_FIFO - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SIZE_FIFO);

  logic [DATA_SIZE-1:0] mem [SIZE_FIFO];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: mid-bit oversampled 8E1-style frames into an RX FIFO drained by read_data.
// Word appears on bus_data the cycle after its stop-bit sample; a push into a full FIFO is dropped and flagged.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int SIZE_FIFO      = 8,
  parameter int OVERSAMPLE     = 16,
  parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_data_in,
  input  logic                 read_data,
  input  logic                 clear_status,
  output logic [DATA_SIZE-1:0] bus_data,
  output logic [7:0]           status_register
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BIT_COUNT_SIZE-1:0] BIT_LAST = BIT_COUNT_SIZE'(DATA_SIZE - 1);

  logic sync_1, rx_s, rx_s_prev;
  logic fall;

  rx_state_t state, state_next;
  logic [TW-1:0]             tick_cnt;
  logic [BIT_COUNT_SIZE-1:0] bit_count;
  logic [DATA_SIZE-1:0]      shift_reg;
  logic                      par_bad;
  logic tick_clr, shift_en, par_en, stop_en;

  logic push, fifo_full, fifo_empty;
  logic parity_error, framing_error, overrun_error;
  logic parity_evt, framing_evt, overrun_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1    <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_prev <= 1'b1;
    end else begin
      sync_1    <= serial_data_in;
      rx_s      <= sync_1;
      rx_s_prev <= rx_s;
    end
  end

  assign fall = rx_s_prev && !rx_s;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    tick_clr   = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    case (state)
      IDLE: begin
        tick_clr = 1'b1;
        if (fall) state_next = START;
      end
      START: begin
        if (tick_cnt == TICK_MID) begin
          tick_clr   = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_cnt == TICK_END) begin
          shift_en = 1'b1;
          if (bit_count == BIT_LAST) state_next = PARITY;
        end
      end
      PARITY: begin
        if (tick_cnt == TICK_END) begin
          par_en     = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick_cnt == TICK_END) begin
          stop_en    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      bit_count <= '0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
    end else begin
      if (tick_clr || tick_cnt == TICK_END) tick_cnt <= '0;
      else                                  tick_cnt <= tick_cnt + 1'b1;

      if (shift_en)           bit_count <= bit_count + 1'b1;
      else if (state != DATA) bit_count <= '0;

      // LSB arrives first, so shifting in from the top leaves it in bit 0.
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_SIZE-1:1]};
      if (par_en)   par_bad   <= rx_s ^ (^shift_reg);
    end
  end

  assign push        = stop_en && rx_s;
  assign framing_evt = stop_en && !rx_s;
  assign parity_evt  = push && par_bad;
  assign overrun_evt = push && fifo_full && !read_data;

  uart_sync_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .SIZE_FIFO (SIZE_FIFO)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (read_data),
    .din   (shift_reg),
    .dout  (bus_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A new error event in the same cycle as clear_status keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      parity_error  <= parity_evt  || (parity_error  && !clear_status);
      framing_error <= framing_evt || (framing_error && !clear_status);
      overrun_error <= overrun_evt || (overrun_error && !clear_status);
    end
  end

  always_comb begin
    status_register             = 8'h00;
    status_register[ST_EMPTY]   = fifo_empty;
    status_register[ST_FULL]    = fifo_full;
    status_register[ST_PARITY]  = parity_error;
    status_register[ST_FRAMING] = framing_error;
    status_register[ST_OVERRUN] = overrun_error;
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: stimulus queues expected words, a monitor drains and compares them.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_data_in;
  logic       read_data;
  logic       clear_status;
  logic [7:0] bus_data;
  logic [7:0] status_register;

  int  checks = 0;
  int  passes = 0;
  bit  drain_en = 1'b0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_receiver dut (
    .clk             (clk),
    .reset           (reset),
    .serial_data_in  (serial_data_in),
    .read_data       (read_data),
    .clear_status    (clear_status),
    .bus_data        (bus_data),
    .status_register (status_register)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    serial_data_in = b;
    idle(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    serial_data_in = 1'b1;
    idle(16);
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    send_frame(d, ^d, 1'b1);
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    idle(1);
    clear_status = 1'b0;
    idle(1);
  endtask

  // Enable the monitor and wait (bounded) until every queued word has been read.
  task automatic drain(input string name);
    int n = 0;
    drain_en = 1'b1;
    while ((exp_q.size() != 0 || !status_register[0]) && n < 400) begin
      idle(1);
      n++;
    end
    drain_en = 1'b0;
    idle(2);
    checks++;
    if (n < 400) passes++;
    else $display("FAIL %s drain timeout: %0d words outstanding, expected 0", name, exp_q.size());
  endtask

  initial begin
    read_data = 1'b0;
    forever begin
      @(negedge clk);
      read_data = 1'b0;
      if (drain_en && !status_register[0]) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %h expected none", bus_data);
        end else begin
          check("rx_word", bus_data, exp_q.pop_front());
        end
        read_data = 1'b1;
      end
    end
  end

  initial begin
    reset          = 1'b1;
    serial_data_in = 1'b1;
    clear_status   = 1'b0;
    idle(3);
    check("reset_status", status_register, 8'h01);
    check("reset_bus", bus_data, 8'h00);
    reset = 1'b0;
    idle(20);

    // Good frame A5
    send_good(8'hA5);
    check("a5_status", status_register, 8'h00);
    drain("a5");
    check("a5_after_read", status_register, 8'h01);

    // Parity error on 07, word still stored
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_status", status_register, 8'h04);
    pulse_clear();
    check("par_cleared", status_register, 8'h00);
    drain("par");

    // Framing error then a good copy of the same word
    send_frame(8'h3C, ^8'h3C, 1'b0);
    check("frame_status", status_register, 8'h09);
    send_good(8'h3C);
    check("frame_recover_status", status_register, 8'h08);
    drain("frame");
    pulse_clear();
    check("frame_cleared", status_register, 8'h01);

    // Short glitch: false start, nothing happens
    serial_data_in = 1'b0;
    idle(6);
    serial_data_in = 1'b1;
    idle(40);
    check("glitch_status", status_register, 8'h01);

    // Overrun: nine frames, eighth fills, ninth is lost
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'(i));
      send_frame(8'(i), ^(8'(i)), 1'b1);
    end
    check("overrun_status", status_register, 8'h12);
    drain("overrun");
    check("overrun_sticky", status_register, 8'h11);
    pulse_clear();
    check("overrun_cleared", status_register, 8'h01);

    // Reset mid-DATA of FF, then a clean 55 frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset = 1'b1;
    idle(1);
    check("midframe_reset", status_register, 8'h01);
    reset = 1'b0;
    idle(40);
    check("post_reset_idle", status_register, 8'h01);
    send_good(8'h55);
    check("post_reset_word", status_register, 8'h00);
    drain("post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
